// File: rtl/pmem_responder.sv
// ----------------------------------------------------------------------------
// pmem_responder
//   Behavioural physical-memory responder for cache-line traffic. It accepts
//   one 256-bit line read or write at a time, waits a fixed LATENCY, then
//   completes the transfer and pulses resp for one cycle. Protocol misuse is
//   recorded in a sticky error flag.
//
// Parameters
//   LATENCY     clock edges from request acceptance to the resp-raising edge
//               (legal range 1..255)
//   INDEX_BITS  line-index width; storage depth is 2**INDEX_BITS lines
//
// Ports
//   clk      single clock, rising-edge active
//   rst      synchronous active-high reset
//   read     line read request, held high until resp
//   write    line write request, held high until resp
//   address  byte address; line index = address[INDEX_BITS+4:5]
//   wdata    write line data
//   resp     one-cycle completion pulse (registered)
//   rdata    last completed read line (registered)
//   error    sticky protocol-violation flag (registered)
// ----------------------------------------------------------------------------
module pmem_responder #(
   parameter int unsigned LATENCY    = 10,
   parameter int unsigned INDEX_BITS = 11
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         read,
   input  logic         write,
   input  logic [15:0]  address,
   input  logic [255:0] wdata,
   output logic         resp,
   output logic [255:0] rdata,
   output logic         error
);

   localparam int unsigned LINE_W = 256;
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned DEPTH  = 1 << INDEX_BITS;
   localparam int unsigned OFS_W  = 5;

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_BUSY    = 2'd1;
   localparam logic [1:0] S_RESP    = 2'd2;
   localparam logic [1:0] S_RECOVER = 2'd3;

   // FSM and transaction registers
   logic [1:0]            state_q;
   logic [1:0]            next_state;
   logic [CNT_W-1:0]      cnt_q;
   logic                  op_read_q;
   logic [INDEX_BITS-1:0] idx_q;
   logic [LINE_W-1:0]     wdata_q;

   // Line storage; deliberately not cleared by reset
   logic [LINE_W-1:0]     mem [DEPTH];

   // Decoded control strobes
   logic                  req_c;
   logic                  accept_c;
   logic                  complete_c;
   logic                  resp_violation_c;
   logic [INDEX_BITS-1:0] addr_idx_c;

   // Low offset bits and any bits above the index do not select a line
   logic                  addr_unused_c;
   assign addr_unused_c = ^address;

   assign req_c      = read | write;
   assign addr_idx_c = address[INDEX_BITS+OFS_W-1:OFS_W];

   // The request line matching the latched op must stay high through RESP
   assign resp_violation_c = (state_q == S_RESP) &&
                             (op_read_q ? !read : !write);

   // Next-state and transaction strobes
   always_comb begin
      next_state = state_q;
      accept_c   = 1'b0;
      complete_c = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req_c) begin
               accept_c   = 1'b1;
               next_state = S_BUSY;
            end
         end
         S_BUSY: begin
            // A dropped request wins over completion, even on the last edge
            if (!req_c) begin
               next_state = S_IDLE;
            end else if (cnt_q == '0) begin
               complete_c = 1'b1;
               next_state = S_RESP;
            end
         end
         S_RESP: begin
            next_state = S_RECOVER;
         end
         S_RECOVER: begin
            // One dead cycle so a request still held after resp is not re-taken
            next_state = S_IDLE;
         end
         default: begin
            next_state = S_IDLE;
         end
      endcase
   end

   // State, counter, latched request and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         op_read_q <= 1'b0;
         idx_q     <= '0;
         wdata_q   <= '0;
         resp      <= 1'b0;
         rdata     <= '0;
         error     <= 1'b0;
      end else begin
         state_q <= next_state;
         resp    <= complete_c;

         if (accept_c) begin
            // Simultaneous read and write is served as a read
            op_read_q <= read;
            idx_q     <= addr_idx_c;
            wdata_q   <= wdata;
            cnt_q     <= CNT_LOAD;
         end else if ((state_q == S_BUSY) && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CNT_W'(1);
         end

         if (complete_c && op_read_q) begin
            rdata <= mem[idx_q];
         end

         if ((accept_c && read && write) || resp_violation_c) begin
            error <= 1'b1;
         end
      end
   end

   // Array write at the RESP-entry edge; suppressed while reset is applied
   always_ff @(posedge clk) begin
      if (!rst && complete_c && !op_read_q) begin
         mem[idx_q] <= wdata_q;
      end
   end

endmodule

// File: tb/tb_pmem_responder.sv
module tb_pmem_responder;

   localparam int unsigned LAT  = 10;
   localparam int unsigned IB   = 11;
   localparam int unsigned LAT1 = 1;

   typedef struct {
      int           cyc;
      logic [255:0] data;
      bit           known;
      logic         err;
   } exp_t;

   logic         clk;
   logic         rst;
   logic         read, write;
   logic [15:0]  address;
   logic [255:0] wdata;
   logic         resp;
   logic [255:0] rdata;
   logic         error;

   logic         read1, write1;
   logic [15:0]  address1;
   logic [255:0] wdata1;
   logic         resp1;
   logic [255:0] rdata1;
   logic         error1;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // Reference model state
   exp_t         exp_q[$];
   logic [255:0] ref_mem [int];
   logic [255:0] last_rd;
   bit           last_known;
   logic         err_m;

   pmem_responder #(.LATENCY(LAT), .INDEX_BITS(IB)) dut (
      .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
      .wdata(wdata), .resp(resp), .rdata(rdata), .error(error));

   pmem_responder #(.LATENCY(LAT1), .INDEX_BITS(4)) dut1 (
      .clk(clk), .rst(rst), .read(read1), .write(write1), .address(address1),
      .wdata(wdata1), .resp(resp1), .rdata(rdata1), .error(error1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] v;
      for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic int line_of(input logic [15:0] a);
      return int'(a >> 5) & ((1 << IB) - 1);
   endfunction

   function automatic logic [15:0] rand_addr();
      int line;
      line = int'($urandom_range(0, 7));
      if (line >= 4) line += 2040;
      return 16'(line << 5) | 16'($urandom_range(0, 31));
   endfunction

   // Scoreboard monitor: every resp pulse must match the oldest expectation
   always @(negedge clk) begin
      if (resp === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_resp", 256'(cyc), 256'(0));
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("resp_cycle", 256'(cyc), 256'(e.cyc));
            if (e.known) check("rdata", rdata, e.data);
            check("resp_error", 256'(error), 256'(e.err));
         end
      end
   end

   task automatic model_reset();
      last_rd    = '0;
      last_known = 1'b1;
      err_m      = 1'b0;
   endtask

   // One transaction starting at a negedge with the DUT idle; returns at a
   // negedge with the DUT idle again. drop_at>0 drops the request so it is
   // seen low at edge E0+drop_at; early releases it during the resp cycle.
   task automatic txn(input bit rd, input bit wr, input logic [15:0] a,
                      input logic [255:0] d, input int drop_at, input bit early);
      int   e0;
      int   idx;
      exp_t e;
      read = rd; write = wr; address = a; wdata = d;
      e0  = cyc + 1;
      idx = line_of(a);
      if (rd && wr) err_m = 1'b1;
      @(negedge clk);
      address = 16'($urandom);
      wdata   = rand256();
      if (drop_at > 0) begin
         repeat (drop_at - 1) @(negedge clk);
         read = 1'b0; write = 1'b0;
         @(negedge clk);
      end else begin
         e.cyc = e0 + int'(LAT);
         e.err = err_m;
         if (rd) begin
            e.known = ref_mem.exists(idx);
            e.data  = e.known ? ref_mem[idx] : '0;
            last_rd = e.data; last_known = e.known;
         end else begin
            e.known = last_known;
            e.data  = last_rd;
            ref_mem[idx] = d;
         end
         exp_q.push_back(e);
         repeat (LAT) @(negedge clk);
         if (early) begin
            read = 1'b0; write = 1'b0;
            err_m = 1'b1;
         end
         @(negedge clk);
         read = 1'b0; write = 1'b0;
         @(negedge clk);
      end
   endtask

   logic [255:0] a5, v1, v2;

   initial begin
      int e0;
      exp_t e;
      a5 = '0;
      for (int i = 0; i < 32; i++) a5[i*8 +: 8] = 8'hA5;
      rst = 1'b1; read = 0; write = 0; address = '0; wdata = '0;
      read1 = 0; write1 = 0; address1 = '0; wdata1 = '0;
      model_reset();
      repeat (3) @(negedge clk);
      check("reset_resp", 256'(resp), 256'(0));
      check("reset_rdata", rdata, 256'(0));
      check("reset_error", 256'(error), 256'(0));
      rst = 1'b0;

      // Write then read the same line through different offsets
      txn(0, 1, 16'h0040, a5, 0, 0);
      txn(1, 0, 16'h005F, a5 ^ a5, 0, 0);

      // Read held beyond resp: one dead cycle, then re-accepted
      read = 1; write = 0; address = 16'h0050;
      e0 = cyc + 1;
      e.cyc = e0 + int'(LAT); e.data = a5; e.known = 1; e.err = err_m;
      exp_q.push_back(e);
      e.cyc = e0 + 2*int'(LAT) + 3;
      exp_q.push_back(e);
      last_rd = a5; last_known = 1;
      repeat (2*LAT + 5) @(negedge clk);
      read = 0;
      @(negedge clk);

      // Aborted write leaves the line untouched
      txn(0, 1, 16'h0040, rand256(), 4, 0);
      txn(1, 0, 16'h0041, '0, 0, 0);

      // Randomized traffic with occasional aborts
      for (int n = 0; n < 30; n++) begin
         bit rd;
         int drop;
         rd   = 1'($urandom_range(0, 1));
         drop = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, LAT)) : 0;
         txn(rd, !rd, rand_addr(), rand256(), drop, 0);
      end
      check("err_clean", 256'(error), 256'(err_m));

      // Request dropped during the resp cycle flags an error
      txn(1, 0, 16'h0040, '0, 0, 1);
      check("err_resp_drop", 256'(error), 256'(err_m));

      // Reset clears error; dual request reads and sets a sticky error
      rst = 1; @(negedge clk); rst = 0; model_reset();
      check("err_cleared", 256'(error), 256'(0));
      txn(1, 1, 16'h0044, rand256(), 0, 0);
      check("err_dual", 256'(error), 256'(1));
      txn(0, 1, 16'h0080, rand256(), 0, 0);
      txn(1, 0, 16'h0080, '0, 0, 0);
      check("err_sticky", 256'(error), 256'(1));

      // Reset mid-write: no resp, line unchanged, and the request on the
      // first edge after reset is accepted
      v1 = rand256(); v2 = ~v1;
      txn(0, 1, 16'h0120, v1, 0, 0);
      read = 0; write = 1; address = 16'h0120; wdata = v2;
      repeat (5) @(negedge clk);
      rst = 1;
      @(negedge clk);
      rst = 0; write = 0; model_reset();
      check("rst_mid_rdata", rdata, 256'(0));
      check("rst_mid_error", 256'(error), 256'(0));
      txn(1, 0, 16'h0120, '0, 0, 0);

      // Minimum latency instance
      write1 = 1; address1 = 16'h0020; wdata1 = v2;
      @(negedge clk);
      check("l1_wr_resp_early", 256'(resp1), 256'(0));
      @(negedge clk);
      check("l1_wr_resp", 256'(resp1), 256'(1));
      @(negedge clk);
      check("l1_wr_resp_width", 256'(resp1), 256'(0));
      write1 = 0;
      @(negedge clk);
      read1 = 1; address1 = 16'h003C;
      @(negedge clk);
      check("l1_rd_resp_early", 256'(resp1), 256'(0));
      @(negedge clk);
      check("l1_rd_resp", 256'(resp1), 256'(1));
      check("l1_rd_data", rdata1, v2);
      @(negedge clk);
      read1 = 0;
      check("l1_error", 256'(error1), 256'(0));

      repeat (LAT + 4) @(negedge clk);
      check("scoreboard_drained", 256'(exp_q.size()), 256'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pmem_responder.md
PMEM_RESPONDER -- requirements
Module: pmem_responder

Interface
REQ-001 SHALL have parameter LATENCY, default 10, meaning clock edges from request acceptance to resp; legal range 1..255.
REQ-002 SHALL have parameter INDEX_BITS, default 11, meaning the line-index width; storage depth is 2**INDEX_BITS lines of 256 bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port read, input, 1 bit: line read request, held high until resp.
REQ-006 SHALL have port write, input, 1 bit: line write request, held high until resp.
REQ-007 SHALL have port address, input, lc3b_word (16 bits): byte address; line index = address[INDEX_BITS+4:5], and address[4:0] is ignored.
REQ-008 SHALL have port wdata, input, lc3b_256: write line data.
REQ-009 SHALL have port resp, output, 1 bit: one-cycle completion pulse.
REQ-010 SHALL have port rdata, output, lc3b_256: registered read line data.
REQ-011 SHALL have port error, output, 1 bit: sticky protocol-violation flag.

Function
REQ-012 SHALL implement a state machine with states IDLE, BUSY, RESP and RECOVER.
REQ-013 In IDLE with read or write high at edge E0: SHALL latch op, line index and wdata, load counter = LATENCY-1, and go to BUSY.
REQ-014 In BUSY: SHALL decrement the counter each edge while counter > 0; at the edge where counter == 0, SHALL perform the op and go to RESP.
REQ-015 resp SHALL be high exactly during the cycle following edge E0+LATENCY, and low at all other times.
REQ-016 Write: SHALL store the latched wdata into the latched line at the RESP-entry edge; rdata SHALL be unchanged.
REQ-017 Read: SHALL load rdata from the latched line at the RESP-entry edge; rdata SHALL hold that value until the next completed read.
REQ-018 RESP SHALL go to RECOVER unconditionally; RECOVER SHALL go to IDLE unconditionally, ignoring read/write, so a request still high for one cycle after resp is not re-accepted.
REQ-019 Address and wdata changes after acceptance SHALL have no effect; the latched values are used.
REQ-020 If read and write are both low at any edge in BUSY: SHALL abort to IDLE with no resp, no array write and no rdata change.
REQ-021 If read and write are both high at acceptance: SHALL perform a read, ignore write, and set error.
REQ-022 If read or write is low during the RESP cycle: SHALL set error; the transaction is still complete.
REQ-023 Once set, error SHALL remain high until rst.
REQ-024 SHALL handle exactly one outstanding transaction, with no queuing.

Reset
REQ-025 While rst is high at an edge: state SHALL go to IDLE, the counter SHALL go to 0, and resp, rdata and error SHALL go to 0.
REQ-026 rst asserted mid-transaction SHALL abort the transaction with no resp and no array write.
REQ-027 The storage array SHALL NOT be cleared by rst.
REQ-028 A request high on the first edge after rst deasserts SHALL be accepted normally.

Verification
REQ-029 With LATENCY=10: write addr 0x0040, wdata 256'hA5..A5 held -> resp high exactly in the cycle after edge E0+10, one cycle wide; rdata still 0.
REQ-030 Then read addr 0x005F (same line) -> rdata == 256'hA5..A5 during resp; addresses 0x0040..0x005F all map to the same line.
REQ-031 Read held high two cycles after resp -> no second resp within LATENCY+2 cycles, then re-acceptance.
REQ-032 Write accepted, then read/write dropped at edge E0+4 -> no resp; a later read of that line returns prior contents.
REQ-033 read=write=1 at acceptance -> read performed, error=1 and stays 1 until rst.
REQ-034 rst pulsed at edge E0+5 of a write -> resp never asserted, line unchanged; LATENCY=1 read -> resp in the cycle after edge E0+1.
